// File: rtl/seg_7_pkg.sv
// ----------------------------------------------------------------------------
// seg_7_pkg
// Shared constants for the seven-segment display family: active-low segment
// patterns (bit order {g,f,e,d,c,b,a}, 0 = segment lit), the 4-bit digit
// classification codes, and the decoder FSM state encoding. The display driver
// seg_7_dynamic imports the same patterns, so that driver and decoder agree by
// construction.
// ----------------------------------------------------------------------------
package seg_7_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0 = 7'b100_0000;
    localparam logic [6:0] SEG_1 = 7'b111_1001;
    localparam logic [6:0] SEG_2 = 7'b010_0100;
    localparam logic [6:0] SEG_3 = 7'b011_0000;
    localparam logic [6:0] SEG_4 = 7'b001_1001;
    localparam logic [6:0] SEG_5 = 7'b001_0010;
    localparam logic [6:0] SEG_6 = 7'b000_0010;
    localparam logic [6:0] SEG_7 = 7'b111_1000;
    localparam logic [6:0] SEG_8 = 7'b000_0000;
    localparam logic [6:0] SEG_9 = 7'b001_0000;
    localparam logic [6:0] MINUS = 7'b011_1111;  // only segment g lit
    localparam logic [6:0] IDLE  = 7'b111_1111;  // all segments dark

    // Classification codes; 0..9 are the digit values themselves
    localparam logic [3:0] CODE_MINUS = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd11;
    localparam logic [3:0] CODE_BAD   = 4'd15;

    localparam int NUM_DIGITS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/seg_7_decode_if.sv
// ----------------------------------------------------------------------------
// seg_7_decode_if
// Request/result bundle of the seven-segment decoder.
//   start       request a decode of seg0..seg5
//   seg0..seg5  active-low patterns, seg0 = units, seg5 = hundred-thousands
//   busy        decoder is working on a captured image
//   done        one-cycle pulse, results valid from this cycle
//   number      decoded magnitude (binary, 20 bits)
//   minus_sign  decoded sign
//   error       pattern set is not a legal display image
// master: the requester; slave: the decoder.
// ----------------------------------------------------------------------------
interface seg_7_decode_if;

    logic        start;
    logic [6:0]  seg0;
    logic [6:0]  seg1;
    logic [6:0]  seg2;
    logic [6:0]  seg3;
    logic [6:0]  seg4;
    logic [6:0]  seg5;
    logic        busy;
    logic        done;
    logic [19:0] number;
    logic        minus_sign;
    logic        error;

    modport master (
        output start, seg0, seg1, seg2, seg3, seg4, seg5,
        input  busy, done, number, minus_sign, error
    );

    modport slave (
        input  start, seg0, seg1, seg2, seg3, seg4, seg5,
        output busy, done, number, minus_sign, error
    );

endinterface

// File: rtl/seg_7_classify.sv
// ----------------------------------------------------------------------------
// seg_7_classify
// Combinational map from one active-low segment pattern to a 4-bit code:
// digit patterns give 0..9, MINUS gives CODE_MINUS, IDLE gives CODE_BLANK and
// every other pattern gives CODE_BAD.
//   seg   in  7  active-low pattern
//   code  out 4  classification code
// ----------------------------------------------------------------------------
module seg_7_classify
    import seg_7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_BAD;
        case (seg)
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            MINUS:   code = CODE_MINUS;
            IDLE:    code = CODE_BLANK;
            default: code = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg_7_decode.sv
// ----------------------------------------------------------------------------
// seg_7_decode
// Recovers the magnitude and sign shown on a six-digit active-low seven
// segment image. On an accepted start the six patterns are captured, then
// scanned one digit per cycle from seg5 down to seg0 while the legality flags
// and a decimal accumulator are updated. One DONE cycle then publishes the
// result, which is held until the next decode completes.
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   bus         slave side of seg_7_decode_if (start, seg0..5 in;
//               busy, done, number, minus_sign, error out)
// ----------------------------------------------------------------------------
module seg_7_decode
    import seg_7_pkg::*;
(
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    seg_7_decode_if.slave  bus
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [6:0]  cap_q [NUM_DIGITS];
    logic [6:0]  cap_d [NUM_DIGITS];
    logic [19:0] acc_q, acc_d;
    logic        seen_digit_q, seen_digit_d;
    logic        seen_minus_q, seen_minus_d;
    logic        lead_zero_q, lead_zero_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [19:0] number_q, number_d;
    logic        minus_sign_q, minus_sign_d;
    logic        error_q, error_d;

    logic [6:0]  cur_seg;
    logic [3:0]  cur_code;
    logic        accept;

    // Select the captured digit under scan
    always_comb begin
        cur_seg = IDLE;
        case (idx_q)
            3'd0:    cur_seg = cap_q[0];
            3'd1:    cur_seg = cap_q[1];
            3'd2:    cur_seg = cap_q[2];
            3'd3:    cur_seg = cap_q[3];
            3'd4:    cur_seg = cap_q[4];
            3'd5:    cur_seg = cap_q[5];
            default: cur_seg = IDLE;
        endcase
    end

    seg_7_classify u_classify (
        .seg  (cur_seg),
        .code (cur_code)
    );

    // busy stays high through the done cycle, so a start is only taken once
    // the published result has been seen.
    assign accept = (state_q == ST_IDLE) && !busy_q && bus.start;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cap_d        = cap_q;
        acc_d        = acc_q;
        seen_digit_d = seen_digit_q;
        seen_minus_d = seen_minus_q;
        lead_zero_d  = lead_zero_q;
        err_d        = err_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        number_d     = number_q;
        minus_sign_d = minus_sign_q;
        error_d      = error_q;

        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cap_d[0]     = bus.seg0;
                    cap_d[1]     = bus.seg1;
                    cap_d[2]     = bus.seg2;
                    cap_d[3]     = bus.seg3;
                    cap_d[4]     = bus.seg4;
                    cap_d[5]     = bus.seg5;
                    idx_d        = 3'd5;
                    acc_d        = 20'd0;
                    seen_digit_d = 1'b0;
                    seen_minus_d = 1'b0;
                    lead_zero_d  = 1'b0;
                    err_d        = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (cur_code == CODE_BAD) begin
                    err_d = 1'b1;
                end else if (cur_code == CODE_BLANK) begin
                    // Blanks are only legal as leading padding
                    if (seen_digit_q || seen_minus_q) begin
                        err_d = 1'b1;
                    end
                end else if (cur_code == CODE_MINUS) begin
                    // One minus, before any digit, and never in the units
                    // place so that a digit always follows it. Anything other
                    // than a digit after it is caught by the blank/minus rules.
                    if (seen_minus_q || seen_digit_q || (idx_q == 3'd0)) begin
                        err_d = 1'b1;
                    end
                    seen_minus_d = 1'b1;
                end else if (is_digit(cur_code)) begin
                    // A leading zero is only legal as the last digit, and
                    // never directly behind a minus ("-0", "-05").
                    if (lead_zero_q) begin
                        err_d = 1'b1;
                    end
                    if (!seen_digit_q && (cur_code == 4'd0)) begin
                        lead_zero_d = 1'b1;
                        if (seen_minus_q) begin
                            err_d = 1'b1;
                        end
                    end
                    seen_digit_d = 1'b1;
                    acc_d = (acc_q << 3) + (acc_q << 1) + {16'd0, cur_code};
                end else begin
                    err_d = 1'b1;
                end

                // All six positions are always scanned: latency is fixed
                if (idx_q == 3'd0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (err_q || !seen_digit_q) begin
                    number_d     = 20'd0;
                    minus_sign_d = 1'b0;
                    error_d      = 1'b1;
                end else begin
                    number_d     = acc_q;
                    minus_sign_d = seen_minus_q;
                    error_d      = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                cap_q[i] <= IDLE;
            end
            acc_q        <= 20'd0;
            seen_digit_q <= 1'b0;
            seen_minus_q <= 1'b0;
            lead_zero_q  <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            number_q     <= 20'd0;
            minus_sign_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cap_q        <= cap_d;
            acc_q        <= acc_d;
            seen_digit_q <= seen_digit_d;
            seen_minus_q <= seen_minus_d;
            lead_zero_q  <= lead_zero_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            number_q     <= number_d;
            minus_sign_q <= minus_sign_d;
            error_q      <= error_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.number     = number_q;
    assign bus.minus_sign = minus_sign_q;
    assign bus.error      = error_q;

endmodule

// File: tb/tb_seg_7_decode.sv
// ----------------------------------------------------------------------------
// tb_seg_7_decode
// Directed and loopback stimulus for seg_7_decode. The driver pushes each
// expected result (value, sign, error flag and the cycle done must appear on)
// into a queue; an independent monitor pops and compares on every done pulse.
// ----------------------------------------------------------------------------
module tb_seg_7_decode;

    typedef struct {
        logic [19:0] num;
        logic        neg;
        logic        err;
        int          cyc;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    exp_t exp_q[$];

    localparam logic [6:0] BL = 7'b111_1111;
    localparam logic [6:0] MI = 7'b011_1111;

    seg_7_decode_if bus ();

    seg_7_decode dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            default: return 7'b001_0000;
        endcase
    endfunction

    function automatic logic [41:0] pk(input logic [6:0] s5, input logic [6:0] s4,
                                       input logic [6:0] s3, input logic [6:0] s2,
                                       input logic [6:0] s1, input logic [6:0] s0);
        return {s5, s4, s3, s2, s1, s0};
    endfunction

    // Display image as the driver produces it: right-justified digits,
    // blank padding, minus directly left of the most significant digit.
    function automatic logic [41:0] enc(input int n, input bit neg);
        logic [41:0] r;
        int v;
        int nd;
        r  = {6{BL}};
        v  = n;
        nd = 0;
        if (n == 0) begin
            r[6:0] = pat(0);
            nd = 1;
        end else begin
            while (v > 0) begin
                r[nd*7 +: 7] = pat(v % 10);
                v = v / 10;
                nd++;
            end
        end
        if (neg && (n != 0) && (nd < 6)) r[nd*7 +: 7] = MI;
        return r;
    endfunction

    task automatic drive_segs(input logic [41:0] s);
        bus.seg5 = s[41:35];
        bus.seg4 = s[34:28];
        bus.seg3 = s[27:21];
        bus.seg2 = s[20:14];
        bus.seg1 = s[13:7];
        bus.seg0 = s[6:0];
    endtask

    task automatic wait_not_busy();
        int w;
        w = 0;
        while (bus.busy && (w < 40)) begin
            @(negedge sys_clk);
            w++;
        end
        if (w >= 40) chk("busy_timeout", 1, 0);
    endtask

    task automatic wait_drained(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0) && (w < 20)) begin
            @(negedge sys_clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_done_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // One decode: issue start for one cycle, record the expectation.
    task automatic run_vec(input string name, input logic [41:0] s,
                           input logic [19:0] n, input logic ng, input logic er);
        exp_t e;
        wait_not_busy();
        drive_segs(s);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        drive_segs({6{BL}});
        e.num = n;
        e.neg = ng;
        e.err = er;
        e.cyc = cyc + 7;
        exp_q.push_back(e);
        chk({name, "_busy"}, int'(bus.busy), 1);
        wait_drained(name);
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst_n && (bus.done === 1'b1)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("number", int'(bus.number), int'(e.num));
                chk("minus_sign", int'(bus.minus_sign), int'(e.neg));
                chk("error", int'(bus.error), int'(e.err));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        exp_t e;
        int n;
        bit ng;

        bus.start = 1'b0;
        drive_segs({6{BL}});
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_number", int'(bus.number), 0);
        chk("rst_minus", int'(bus.minus_sign), 0);
        chk("rst_error", int'(bus.error), 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        // Legal images
        run_vec("v123", pk(BL, BL, BL, pat(1), pat(2), pat(3)), 20'd123, 1'b0, 1'b0);
        run_vec("vm405", pk(BL, BL, MI, pat(4), pat(0), pat(5)), 20'd405, 1'b1, 1'b0);
        run_vec("v999999", {6{pat(9)}}, 20'd999999, 1'b0, 1'b0);
        run_vec("vm12345", pk(MI, pat(1), pat(2), pat(3), pat(4), pat(5)), 20'd12345, 1'b1, 1'b0);
        run_vec("vzero", pk(BL, BL, BL, BL, BL, pat(0)), 20'd0, 1'b0, 1'b0);

        // Illegal images
        run_vec("lead0", pk(BL, BL, BL, BL, pat(0), pat(7)), 20'd0, 1'b0, 1'b1);
        run_vec("minus0", pk(BL, BL, BL, BL, MI, pat(0)), 20'd0, 1'b0, 1'b1);
        run_vec("allidle", {6{BL}}, 20'd0, 1'b0, 1'b1);
        run_vec("minus_units", pk(BL, BL, BL, BL, BL, MI), 20'd0, 1'b0, 1'b1);
        run_vec("badpat", pk(BL, BL, BL, pat(1), 7'b111_1110, pat(3)), 20'd0, 1'b0, 1'b1);
        run_vec("gap", pk(BL, BL, BL, pat(1), BL, pat(2)), 20'd0, 1'b0, 1'b1);
        run_vec("twominus", pk(BL, BL, MI, MI, pat(1), pat(2)), 20'd0, 1'b0, 1'b1);

        // Start held high with changing images: only the first is taken
        wait_not_busy();
        drive_segs(enc(11, 1'b0));
        bus.start = 1'b1;
        @(negedge sys_clk);
        e.num = 20'd11;
        e.neg = 1'b0;
        e.err = 1'b0;
        e.cyc = cyc + 7;
        exp_q.push_back(e);
        for (int k = 1; k < 8; k++) begin
            drive_segs(enc(20 + k, 1'b0));
            @(negedge sys_clk);
        end
        bus.start = 1'b0;
        repeat (12) @(negedge sys_clk);
        chk("burst_pending", exp_q.size(), 0);
        exp_q.delete();

        // Leave a non-zero result, then reset in the middle of a scan
        run_vec("pre_rst", pk(BL, BL, BL, BL, pat(4), pat(2)), 20'd42, 1'b0, 1'b0);
        wait_not_busy();
        drive_segs(pk(BL, BL, BL, pat(7), pat(7), pat(7)));
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_number", int'(bus.number), 0);
        chk("midrst_minus", int'(bus.minus_sign), 0);
        chk("midrst_error", int'(bus.error), 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (12) @(negedge sys_clk);
        chk("midrst_number_held", int'(bus.number), 0);
        run_vec("post_rst", pk(BL, BL, BL, BL, BL, pat(8)), 20'd8, 1'b0, 1'b0);

        // Loopback with display-format images
        for (int i = 0; i < 200; i++) begin
            n  = (i % 2 == 0) ? int'($urandom_range(0, 999)) : int'($urandom_range(0, 999999));
            ng = (n <= 99999) ? bit'($urandom_range(0, 1)) : 1'b0;
            run_vec("loop", enc(n, ng), n[19:0], ng && (n != 0), 1'b0);
        end

        repeat (3) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
